// File: rtl/m72_sample_fetch.sv
// m72_sample_fetch
// Sample-ROM address generator and byte fetcher for the M72 8051 sample MCU.
// The MCU loads a byte address through two external-bus write strobes and
// advances it with a read strobe. The addressed byte is fetched from a 16-bit
// SDRAM region through a one-word cache. sample_ready is low whenever the
// presented byte is not yet valid, so the MCU clock-enable can stall on it.
//
// Ports:
//   CLK_32M          system clock
//   reset_n          asynchronous active-low reset
//   sample_addr_wr   [0] loads addr[12:5] (clears addr[4:0]), [1] loads addr[ADDR_W-1:13]
//   sample_addr      address byte written by the MCU
//   sample_inc       advance the byte address by one
//   sample_rom_data  byte at the current address (valid while sample_ready)
//   sample_ready     data valid, no fetch outstanding
//   sdr_addr/sdr_req SDRAM word read request, held until sdr_ack
//   sdr_ack/sdr_data SDRAM read return (data valid with ack)
//   dbg_addr         current byte address
module m72_sample_fetch #(
   parameter int          ADDR_W     = 18,
   parameter logic [23:0] BASE_WADDR = 24'h0
) (
   input  logic              CLK_32M,
   input  logic              reset_n,
   input  logic [1:0]        sample_addr_wr,
   input  logic [7:0]        sample_addr,
   input  logic              sample_inc,
   output logic [7:0]        sample_rom_data,
   output logic              sample_ready,
   output logic [23:0]       sdr_addr,
   output logic              sdr_req,
   input  logic              sdr_ack,
   input  logic [15:0]       sdr_data,
   output logic [ADDR_W-1:0] dbg_addr
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          data_q, data_d;
   logic                ready_q, ready_d;
   logic [23:0]         sdr_addr_q, sdr_addr_d;
   logic                req_q, req_d;
   logic [15:0]         fetch_word_q, fetch_word_d;
   logic [ADDR_W-2:0]   req_tag_q, req_tag_d;
   logic [15:0]         cache_word_q, cache_word_d;
   logic [ADDR_W-2:0]   cache_tag_q, cache_tag_d;
   logic                cache_valid_q, cache_valid_d;
   // eval_q: the current address has not yet been checked against the cache.
   // Set out of reset so the first word is fetched without any MCU access.
   logic                eval_q, eval_d;

   logic                addr_ev;
   logic [ADDR_W-1:0]   addr_n;

   always_comb begin
      state_d       = state_q;
      data_d        = data_q;
      ready_d       = ready_q;
      sdr_addr_d    = sdr_addr_q;
      req_d         = req_q;
      fetch_word_d  = fetch_word_q;
      req_tag_d     = req_tag_q;
      cache_word_d  = cache_word_q;
      cache_tag_d   = cache_tag_q;
      cache_valid_d = cache_valid_q;
      eval_d        = eval_q;

      // Address update: a write strobe wins over an increment in the same cycle.
      addr_ev = (sample_addr_wr != 2'b00) || sample_inc;
      addr_n  = addr_q;
      if (sample_addr_wr != 2'b00) begin
         if (sample_addr_wr[0]) addr_n = {addr_n[ADDR_W-1:13], sample_addr, 5'b0};
         if (sample_addr_wr[1]) addr_n = ADDR_W'({sample_addr, addr_n[12:0]});
      end else if (sample_inc) begin
         addr_n = addr_q + 1'b1;
      end
      addr_d = addr_n;

      case (state_q)
         S_IDLE: begin
            if (eval_q) begin
               eval_d = 1'b0;
               if (cache_valid_q && (cache_tag_q == addr_q[ADDR_W-1:1])) begin
                  data_d  = addr_q[0] ? cache_word_q[15:8] : cache_word_q[7:0];
                  ready_d = 1'b1;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            sdr_addr_d = BASE_WADDR + 24'(addr_q[ADDR_W-1:1]);
            req_tag_d  = addr_q[ADDR_W-1:1];
            req_d      = 1'b1;
            eval_d     = 1'b0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            // The request is never withdrawn; address events here are
            // resolved once the word has come back.
            if (sdr_ack) begin
               fetch_word_d = sdr_data;
               req_d        = 1'b0;
               state_d      = S_DONE;
            end
         end
         S_DONE: begin
            cache_word_d  = fetch_word_q;
            cache_tag_d   = req_tag_q;
            cache_valid_d = 1'b1;
            if (req_tag_q == addr_q[ADDR_W-1:1]) begin
               data_d  = addr_q[0] ? fetch_word_q[15:8] : fetch_word_q[7:0];
               ready_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               // Address moved to another word while the fetch was in flight.
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A new address invalidates whatever is presented this cycle and
      // forces a fresh cache lookup once the FSM is idle.
      if (addr_ev) begin
         ready_d = 1'b0;
         eval_d  = 1'b1;
      end
   end

   always_ff @(posedge CLK_32M or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         data_q        <= '0;
         ready_q       <= 1'b0;
         sdr_addr_q    <= '0;
         req_q         <= 1'b0;
         fetch_word_q  <= '0;
         req_tag_q     <= '0;
         cache_word_q  <= '0;
         cache_tag_q   <= '0;
         cache_valid_q <= 1'b0;
         eval_q        <= 1'b1;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         ready_q       <= ready_d;
         sdr_addr_q    <= sdr_addr_d;
         req_q         <= req_d;
         fetch_word_q  <= fetch_word_d;
         req_tag_q     <= req_tag_d;
         cache_word_q  <= cache_word_d;
         cache_tag_q   <= cache_tag_d;
         cache_valid_q <= cache_valid_d;
         eval_q        <= eval_d;
      end
   end

   assign sample_rom_data = data_q;
   assign sample_ready    = ready_q;
   assign sdr_addr        = sdr_addr_q;
   assign sdr_req         = req_q;
   assign dbg_addr        = addr_q;

endmodule

// File: doc/m72_sample_fetch.md
Name: m72_sample_fetch

Overview:
Sample-ROM address generator and byte fetcher for the M72 8051 sample/protection MCU.
- Holds the sample address register loaded by the MCU's external-bus writes.
- Advances the address on each MCU sample read strobe.
- Fetches the addressed byte from the 16-bit SDRAM sample region and presents it as sample_rom_data.
- Deasserts sample_ready while a fetch is outstanding; the MCU clock-enable is gated on sample_ready, so the MCU stalls until the data is valid.

Parameters:
ADDR_W, 18, byte address width of the sample region; the address wraps modulo 2^ADDR_W.
BASE_WADDR, 24'h0, SDRAM word offset of the sample region, added to the word address.

Ports:
CLK_32M  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
sample_addr_wr  in  2  one-cycle write strobe from the MCU. bit0 loads the low address byte; bit1 loads the high address byte.
sample_addr  in  8  address byte, sampled on sample_addr_wr.
sample_inc  in  1  one-cycle pulse: the current byte has been consumed, advance the address by 1.
sample_rom_data  out  8  byte at the current address; valid while sample_ready=1.
sample_ready  out  1  data valid and no fetch outstanding.
sdr_addr  out  24  SDRAM word address.
sdr_req  out  1  read request; held high until sdr_ack.
sdr_ack  in  1  one-cycle pulse; sdr_data is valid in the same cycle.
sdr_data  in  16  SDRAM read word. Low byte = even byte address.
dbg_addr  out  ADDR_W  current byte address.

Behaviour:
- All state is asynchronously cleared when reset_n=0. Reset values:
  - addr=0, sample_rom_data=0, sample_ready=0, sdr_req=0, sdr_addr=0, cache_valid=0.
  - FSM in IDLE.
- Address loads (byte address, bits beyond ADDR_W are discarded):
  - sample_addr_wr[0]: addr = {addr[ADDR_W-1:13], sample_addr, 5'b0}.
  - sample_addr_wr[1]: addr = {sample_addr, addr[12:0]}, truncated to ADDR_W.
  - sample_addr_wr=2'b11 applies both loads in the same cycle.
- Increment: sample_inc adds 1 to addr. All-ones wraps to 0.
- Priority when both arrive together: sample_addr_wr beats sample_inc; the inc is dropped.
- Word cache: one 16-bit word plus its word address (addr[ADDR_W-1:1]) and cache_valid.
- On any address event:
  - At that edge, addr is updated and sample_ready goes to 0.
  - Hit (cache_valid and same word): at the next edge, sample_rom_data = the selected byte and sample_ready=1. Ready is low for exactly 1 cycle.
  - Miss: FSM goes to REQ.
- FSM states:
  - IDLE: no fetch outstanding.
  - REQ: drive sdr_addr = BASE_WADDR + addr[ADDR_W-1:1] and sdr_req=1, then go to WAIT.
  - WAIT: sdr_req held high; go to DONE on sdr_ack.
  - DONE: load cache (word and tag, cache_valid=1), sample_rom_data = byte select by addr[0], sample_ready=1, return to IDLE.
- Miss latency: ready returns to 1 two cycles after sdr_ack.
- Address event during WAIT:
  - sdr_req stays high; the request is not withdrawn.
  - The returning word still fills the cache, tagged with the requested address.
  - The FSM then re-evaluates the current addr (hit or new REQ).
  - sample_ready stays 0 throughout.
- After reset release the FSM fetches word 0, so sample_ready first rises without any MCU access.
- sdr_addr is stable for the whole request. sdr_req deasserts in the cycle after sdr_ack.
- An sdr_ack arriving while not in WAIT is ignored.
- reset_n asserted mid-fetch: sdr_req drops immediately. The SDRAM controller is reset by the same reset_n.

Test Plan:
- Release reset; ack word 0 with 16'hA55A after 5 cycles -> sample_ready rises 2 cycles after ack, sample_rom_data=8'h5A.
- sample_addr_wr=01 with 8'h03, then 10 with 8'h02 -> addr=0x4060; sdr_addr=0x2030; ack 16'h1234 -> data 8'h34, ready=1.
- From addr 0x4060, pulse sample_inc -> addr 0x4061, cache hit, no sdr_req, ready low 1 cycle, data 8'h12.
- Second sample_inc -> addr 0x4062, miss, sdr_req with sdr_addr=0x2031, ready stays 0 until 2 cycles after ack.
- addr=0x3FFFF, sample_inc -> addr 0, sdr_addr=BASE_WADDR. Simultaneous sample_inc and sample_addr_wr=01 -> load applied, inc dropped.
- sample_addr_wr during WAIT -> sdr_req held, cache filled with old word, new REQ issued for the new word, data matches the new address. Assert reset_n=0 mid-WAIT -> sdr_req=0, ready=0 immediately.
